mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_lane_align.sv | 67 ++++++
 rtl/mem_responder.sv | 118 +++++++++++
 tb/tb_mem_responder.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for mem_responder: RV32I load/store funct3 codes and the responder FSM states.
// Pure declarations; no logic, no latency, no flow control.
package mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between a memory requester (master) and mem_responder (slave).
// Valid/ready request channel; response is a one-cycle strobe with no backpressure.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte-enables/data replication and load lane extraction/extension.
// Zero latency, no flow control; MEM_ALIGN_CHECK_EN adds misaligned half/word rejection.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic        is_write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data,
    output logic        req_err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_en    = '0;
        wdata_lane = '0;
        load_data  = '0;
        req_err    = 1'b0;
        byte_sel   = rword[{addr_lo, 3'b000} +: 8];
        half_sel   = addr_lo[1] ? rword[31:16] : rword[15:0];

        // Store data is replicated across lanes so byte_en alone picks the target bytes.
        if (is_write) begin
            case (funct3)
                SB: begin
                    byte_en    = 4'b0001 << addr_lo;
                    wdata_lane = {4{wdata[7:0]}};
                end
                SH: begin
                    byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_lane = {2{wdata[15:0]}};
                end
                SW: begin
                    byte_en    = 4'b1111;
                    wdata_lane = wdata;
                end
                default: req_err = 1'b1;
            endcase
        end else begin
            case (funct3)
                LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
                LH:      load_data = {{16{half_sel[15]}}, half_sel};
                LW:      load_data = rword;
                LBU:     load_data = {24'd0, byte_sel};
                LHU:     load_data = {16'd0, half_sel};
                default: req_err = 1'b1;
            endcase
        end

`ifdef MEM_ALIGN_CHECK_EN
        if ((funct3[1:0] == 2'b01 && addr_lo[0]) || (funct3[1:0] == 2'b10 && addr_lo != 2'b00))
            req_err = 1'b1;
`endif

        if (req_err) begin
            byte_en   = '0;
            load_data = '0;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding RV32I load/store memory; response WAIT_CYCLES+1 cycles after accept, ready only in IDLE.
// Response strobe has no backpressure; MEM_ALIGN_CHECK_EN enables misalignment errors.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    mem_responder_if.slave    bus
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic            write_q, write_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [1:0]      lo_q, lo_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [2:0]      f3_q, f3_d;

    logic [31:0]     mem_q [DEPTH];
    logic [31:0]     rword;
    logic [3:0]      byte_en;
    logic [31:0]     wdata_lane;
    logic [31:0]     load_data;
    logic            req_err;
    logic            ready;
    logic            accept;
    logic            in_resp;
    logic            mem_we;
    logic            unused_addr_hi;

    assign rword = mem_q[idx_q];

    mem_lane_align u_align (
        .is_write   (write_q),
        .funct3     (f3_q),
        .addr_lo    (lo_q),
        .wdata      (wdata_q),
        .rword      (rword),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .load_data  (load_data),
        .req_err    (req_err)
    );

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        write_d        = write_q;
        idx_d          = idx_q;
        lo_d           = lo_q;
        wdata_d        = wdata_q;
        f3_d           = f3_q;
        unused_addr_hi = ^bus.req_addr[31:AW+2];

        ready   = reset && (state_q == IDLE);
        accept  = bus.req_valid && ready;
        in_resp = reset && (state_q == RESP);

        case (state_q)
            IDLE: if (accept) begin
                write_d    = bus.req_write;
                idx_d      = bus.req_addr[AW+1:2];
                lo_d       = bus.req_addr[1:0];
                wdata_d    = bus.req_wdata;
                f3_d       = bus.req_funct3;
                wait_cnt_d = '0;
                state_d    = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) state_d = RESP;
                else                         wait_cnt_d = wait_cnt_q + 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are gated by reset so a reset landing mid-transaction silences them at once.
        bus.req_ready  = ready;
        bus.resp_valid = in_resp;
        bus.resp_rdata = (in_resp && !write_q) ? load_data : 32'd0;
        bus.resp_err   = in_resp && req_err;
        mem_we         = in_resp && write_q && !req_err;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            write_q    <= 1'b0;
            idx_q      <= '0;
            lo_q       <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            write_q    <= write_d;
            idx_q      <= idx_d;
            lo_q       <= lo_d;
            wdata_q    <= wdata_d;
            f3_q       <= f3_d;
        end
    end

    // Storage is never cleared; a store commits on the edge that ends RESP.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && byte_en[b]) mem_q[idx_q][8*b +: 8] <= wdata_lane[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a zero-wait instance (DEPTH 64) and a three-wait instance (DEPTH 1024),
// directed vector table, multi-cycle corner sequences and random traffic against a byte-array model.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int D0 = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n, rst3_n;
    mem_responder_if i0 ();
    mem_responder_if i3 ();

    mem_responder #(.DEPTH(D0),   .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(rst0_n), .bus(i0));
    mem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) dut3 (.clk(clk), .reset(rst3_n), .bus(i3));

    int nvec = 0;
    int nmis = 0;
    logic [7:0] mbytes [4*D0];

    typedef struct packed {
        logic        rdy;
        logic        vld;
        logic        err;
        logic [31:0] rd;
    } obs_t;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(int sel, logic v, logic w, logic [31:0] a, logic [31:0] d, logic [2:0] f);
        if (sel == 0) begin
            i0.req_valid = v; i0.req_write = w; i0.req_addr = a; i0.req_wdata = d; i0.req_funct3 = f;
        end else begin
            i3.req_valid = v; i3.req_write = w; i3.req_addr = a; i3.req_wdata = d; i3.req_funct3 = f;
        end
    endtask

    function automatic obs_t obs(int sel);
        if (sel == 0) return {i0.req_ready, i0.resp_valid, i0.resp_err, i0.resp_rdata};
        return {i3.req_ready, i3.resp_valid, i3.resp_err, i3.resp_rdata};
    endfunction

    // Reference: little-endian byte memory, addresses wrap at 4*D0.
    function automatic void model(logic w, logic [31:0] a, logic [31:0] d, logic [2:0] f,
                                  output logic [31:0] rd, output logic er);
        int ba, n, base;
        bit ok;
        ba   = int'(a % (4 * D0));
        ok   = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n    = 1 << f[1:0];
        base = ba - (ba % n);
`ifdef MEM_ALIGN_CHECK_EN
        if (ba % n != 0) ok = 1'b0;
`endif
        rd = '0;
        er = !ok;
        if (!ok) return;
        if (w) begin
            for (int i = 0; i < n; i++) mbytes[base+i] = d[8*i +: 8];
        end else begin
            for (int i = 0; i < n; i++) rd[8*i +: 8] = mbytes[base+i];
            if (!f[2] && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8*n)) - 32'd1);
        end
    endfunction

    task automatic txn(int sel, logic w, logic [31:0] a, logic [31:0] d, logic [2:0] f,
                       output logic [31:0] rd, output logic er);
        int lat;
        obs_t o;
        lat = (sel == 0) ? 1 : 4;
        @(negedge clk);
        o = obs(sel);
        chk("ready_idle", 32'(o.rdy), 32'd1);
        set_req(sel, 1'b1, w, a, d, f);
        @(posedge clk);
        #1 set_req(sel, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            o = obs(sel);
            chk("early_valid", 32'(o.vld), 32'd0);
            chk("busy_ready", 32'(o.rdy), 32'd0);
        end
        @(negedge clk);
        o = obs(sel);
        chk("resp_valid", 32'(o.vld), 32'd1);
        chk("resp_ready", 32'(o.rdy), 32'd0);
        rd = o.rd;
        er = o.err;
        @(negedge clk);
        o = obs(sel);
        chk("valid_drop", 32'(o.vld), 32'd0);
        chk("rdata_idle", o.rd, 32'd0);
        chk("err_idle", 32'(o.err), 32'd0);
    endtask

    initial begin
        logic [31:0] rd, mr, a, d;
        logic        er, me, w;
        logic [2:0]  f;
        obs_t        o;
        int          extra;

        tbl.push_back('{1'b1, 32'h10,  32'hDEADBEEF, SW,     32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h10,  32'h0,        LW,     32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b1, 32'h20,  32'h80FF7F01, SW,     32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h23,  32'h0,        LB,     32'hFFFFFF80, 1'b0});
        tbl.push_back('{1'b0, 32'h23,  32'h0,        LBU,    32'h00000080, 1'b0});
        tbl.push_back('{1'b0, 32'h22,  32'h0,        LH,     32'hFFFF80FF, 1'b0});
        tbl.push_back('{1'b0, 32'h20,  32'h0,        LHU,    32'h00007F01, 1'b0});
        tbl.push_back('{1'b1, 32'h20,  32'h11223344, SW,     32'h0,        1'b0});
        tbl.push_back('{1'b1, 32'h21,  32'hFFFFFFAA, SB,     32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h20,  32'h0,        LW,     32'h1122AA44, 1'b0});
        tbl.push_back('{1'b0, 32'h10,  32'h0,        3'b011, 32'h0,        1'b1});
        tbl.push_back('{1'b1, 32'h10,  32'h0,        3'b011, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h10,  32'h0,        LW,     32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b0, 32'h110, 32'h0,        LW,     32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b1, 32'h22,  32'h5555BEEF, SH,     32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h20,  32'h0,        LW,     32'hBEEFAA44, 1'b0});
        tbl.push_back('{1'b1, 32'h20,  32'h0,        3'b100, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h20,  32'h0,        3'b110, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h20,  32'h0,        LW,     32'hBEEFAA44, 1'b0});
`ifdef MEM_ALIGN_CHECK_EN
        tbl.push_back('{1'b1, 32'h13,  32'h12345678, SW,     32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h10,  32'h0,        LW,     32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b0, 32'h11,  32'h0,        LH,     32'h0,        1'b1});
`else
        tbl.push_back('{1'b1, 32'h13,  32'h12345678, SW,     32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h10,  32'h0,        LW,     32'h12345678, 1'b0});
        tbl.push_back('{1'b0, 32'h11,  32'h0,        LH,     32'h00005678, 1'b0});
`endif

        rst0_n = 1'b0;
        rst3_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_req(3, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            o = obs(s * 3);
            chk($sformatf("rst_ready%0d", s), 32'(o.rdy), 32'd0);
            chk($sformatf("rst_valid%0d", s), 32'(o.vld), 32'd0);
            chk($sformatf("rst_rdata%0d", s), o.rd, 32'd0);
            chk($sformatf("rst_err%0d", s), 32'(o.err), 32'd0);
        end
        rst0_n = 1'b1;
        rst3_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready0", 32'(obs(0).rdy), 32'd1);
        chk("post_rst_ready3", 32'(obs(3).rdy), 32'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            txn(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].f, rd, er);
            model(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].f, mr, me);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
        end

        // Three-wait instance: exact latency, and a request pulse during WAIT is dropped.
        txn(3, 1'b1, 32'h40, 32'h01020304, SW, rd, er);
        chk("w3_sw_err", 32'(er), 32'd0);
        @(negedge clk);
        set_req(3, 1'b1, 1'b0, 32'h40, 32'd0, LW);
        @(posedge clk);
        #1 set_req(3, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        @(negedge clk);
        o = obs(3);
        chk("w3_n1_valid", 32'(o.vld), 32'd0);
        chk("w3_n1_ready", 32'(o.rdy), 32'd0);
        set_req(3, 1'b1, 1'b1, 32'h40, 32'hFFFFFFFF, SW);
        @(posedge clk);
        #1 set_req(3, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            o = obs(3);
            chk($sformatf("w3_n%0d_valid", k), 32'(o.vld), 32'd0);
            chk($sformatf("w3_n%0d_ready", k), 32'(o.rdy), 32'd0);
        end
        @(negedge clk);
        o = obs(3);
        chk("w3_n4_valid", 32'(o.vld), 32'd1);
        chk("w3_n4_ready", 32'(o.rdy), 32'd0);
        chk("w3_n4_rdata", o.rd, 32'h01020304);
        @(negedge clk);
        o = obs(3);
        chk("w3_n5_valid", 32'(o.vld), 32'd0);
        chk("w3_n5_ready", 32'(o.rdy), 32'd1);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (obs(3).vld) extra++;
        end
        chk("w3_no_extra_resp", 32'(extra), 32'd0);
        txn(3, 1'b0, 32'h40, 32'd0, LW, rd, er);
        chk("w3_pulse_dropped", rd, 32'h01020304);

        // Reset during WAIT abandons the store.
        @(negedge clk);
        set_req(3, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, SW);
        @(posedge clk);
        #1 set_req(3, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        @(negedge clk);
        rst3_n = 1'b0;
        @(negedge clk);
        o = obs(3);
        chk("wrst_ready", 32'(o.rdy), 32'd0);
        chk("wrst_valid", 32'(o.vld), 32'd0);
        @(negedge clk);
        rst3_n = 1'b1;
        @(negedge clk);
        chk("wrst_ready_after", 32'(obs(3).rdy), 32'd1);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (obs(3).vld) extra++;
        end
        chk("wrst_no_resp", 32'(extra), 32'd0);
        txn(3, 1'b0, 32'h40, 32'd0, LW, rd, er);
        chk("wrst_mem_kept", rd, 32'h01020304);

        // Reset during RESP on the zero-wait instance: strobe silenced, no write.
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 32'h10, 32'h0BADF00D, SW);
        @(posedge clk);
        #1 set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        @(negedge clk);
        chk("rrst_valid_before", 32'(obs(0).vld), 32'd1);
        rst0_n = 1'b0;
        #1 chk("rrst_valid_gated", 32'(obs(0).vld), 32'd0);
        @(negedge clk);
        rst0_n = 1'b1;
        txn(0, 1'b0, 32'h10, 32'd0, LW, rd, er);
        model(1'b0, 32'h10, 32'd0, LW, mr, me);
        chk("rrst_mem_kept", rd, mr);

        for (int i = 0; i < D0; i++) begin
            d = $urandom;
            txn(0, 1'b1, 32'(i * 4), d, SW, rd, er);
            model(1'b1, 32'(i * 4), d, SW, mr, me);
            chk("preload_err", 32'(er), 32'd0);
        end

        for (int i = 0; i < 400; i++) begin
            w = 1'($urandom_range(0, 1));
            a = $urandom;
            d = $urandom;
            f = 3'($urandom_range(0, 7));
            txn(0, w, a, d, f, rd, er);
            model(w, a, d, f, mr, me);
            chk($sformatf("rnd%0d_rdata w=%0d f=%0d a=%h", i, w, f, a), rd, mr);
            chk($sformatf("rnd%0d_err", i), 32'(er), 32'(me));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
